// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural Z/N/V flags, bypassed branch evaluation, registered decision and saturating stats
module flag_branch_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             alu_zr,
  input  logic             alu_neg,
  input  logic             alu_ov,
  input  logic             wr_z,
  input  logic             wr_n,
  input  logic             wr_v,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  input  logic             cnt_clr,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             taken,
  output logic             taken_valid,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_taken
);
  logic       eff_z, eff_n, eff_v, res, acc;
  logic [7:0] cond_tbl;
  always_comb begin
    eff_z    = wr_z ? alu_zr  : flag_z;
    eff_n    = wr_n ? alu_neg : flag_n;
    eff_v    = wr_v ? alu_ov  : flag_v;
    cond_tbl = {1'b1, eff_v, eff_z | eff_n, eff_z | !eff_n, eff_n, !eff_z & !eff_n, eff_z, !eff_z};
    res      = cond_tbl[br_cond];
    acc      = br_valid & !stall & !flush;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b1;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else if (!stall) begin
      flag_z <= eff_z;
      flag_n <= eff_n;
      flag_v <= eff_v;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken       <= 1'b0;
      taken_valid <= 1'b0;
    end else if (flush) begin
      taken       <= 1'b0;
      taken_valid <= 1'b0;
    end else if (!stall) begin
      taken       <= br_valid ? res : taken;
      taken_valid <= br_valid;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_total <= '0;
      br_taken <= '0;
    end else if (cnt_clr) begin
      br_total <= '0;
      br_taken <= '0;
    end else if (acc) begin
      br_total <= &br_total ? br_total : br_total + CNT_W'(1);
      br_taken <= (res && !(&br_taken)) ? br_taken + CNT_W'(1) : br_taken;
    end
  end
endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed and random checks against a behavioural flag/branch model
module tb_flag_branch_unit;
  localparam int CNT_W = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
  logic             alu_zr = 1'b0, alu_neg = 1'b0, alu_ov = 1'b0;
  logic             wr_z = 1'b0, wr_n = 1'b0, wr_v = 1'b0;
  logic             br_valid = 1'b0;
  logic [2:0]       br_cond = 3'd0;
  logic             flag_z, flag_n, flag_v, taken, taken_valid;
  logic [CNT_W-1:0] br_total, br_taken;
  int n_chk = 0, n_err = 0;
  bit m_z, m_n, m_v, m_t, m_tv;
  int m_total, m_taken;
  flag_branch_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .alu_zr(alu_zr), .alu_neg(alu_neg), .alu_ov(alu_ov),
    .wr_z(wr_z), .wr_n(wr_n), .wr_v(wr_v),
    .br_valid(br_valid), .br_cond(br_cond), .cnt_clr(cnt_clr),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .taken(taken), .taken_valid(taken_valid),
    .br_total(br_total), .br_taken(br_taken)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit cond_ok(input int code, input bit z, input bit n, input bit v);
    case (code)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return z || n;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction
  task automatic model_reset();
    m_z = 1; m_n = 0; m_v = 0; m_t = 0; m_tv = 0; m_total = 0; m_taken = 0;
  endtask
  task automatic check_all();
    chk("flag_z", flag_z, m_z);
    chk("flag_n", flag_n, m_n);
    chk("flag_v", flag_v, m_v);
    chk("taken", taken, m_t);
    chk("taken_valid", taken_valid, m_tv);
    chk("br_total", br_total, m_total);
    chk("br_taken", br_taken, m_taken);
  endtask
  task automatic tick();
    bit ez, en, ev, r;
    ez = wr_z ? alu_zr : m_z;
    en = wr_n ? alu_neg : m_n;
    ev = wr_v ? alu_ov : m_v;
    r  = cond_ok(int'(br_cond), ez, en, ev);
    @(posedge clk); #1;
    if (!stall) begin m_z = ez; m_n = en; m_v = ev; end
    if (flush) begin m_t = 0; m_tv = 0; end
    else if (!stall) begin
      if (br_valid) m_t = r;
      m_tv = br_valid;
    end
    if (cnt_clr) begin m_total = 0; m_taken = 0; end
    else if (br_valid && !stall && !flush) begin
      if (m_total < MAXC) m_total++;
      if (r && m_taken < MAXC) m_taken++;
    end
    check_all();
  endtask
  task automatic idle();
    stall = 0; flush = 0; cnt_clr = 0; wr_z = 0; wr_n = 0; wr_v = 0; br_valid = 0;
  endtask
  task automatic set_flags(input bit z, input bit n, input bit v);
    idle();
    wr_z = 1; wr_n = 1; wr_v = 1; alu_zr = z; alu_neg = n; alu_ov = v;
    tick();
    idle();
  endtask
  initial begin
    logic [7:0] exp_znv = 8'hE9;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    @(posedge clk); #1;
    tick();
    // bypass: new Z visible to the branch in the same cycle
    set_flags(0, 0, 0);
    wr_z = 1; alu_zr = 1; br_valid = 1; br_cond = 3'd1;
    tick();
    chk("byp_taken", taken, 1);
    chk("byp_valid", taken_valid, 1);
    chk("byp_flag_z", flag_z, 1);
    set_flags(0, 0, 0);
    wr_z = 0; alu_zr = 1; br_valid = 1; br_cond = 3'd1;
    tick();
    chk("nobyp_taken", taken, 0);
    idle();
    // full sweep of flag combos and condition codes
    for (int f = 0; f < 8; f++) begin
      set_flags(f[2], f[1], f[0]);
      for (int c = 0; c < 8; c++) begin
        br_valid = 1; br_cond = 3'(c);
        tick();
        if (f == 3) chk($sformatf("znv011_c%0d", c), taken, exp_znv[c]);
      end
    end
    idle();
    tick();
    // stall holds a pending decision and blocks flag writes
    set_flags(0, 0, 0);
    br_valid = 1; br_cond = 3'd7;
    tick();
    br_valid = 0; stall = 1; wr_z = 1; wr_n = 1; wr_v = 1; alu_zr = 1; alu_neg = 1; alu_ov = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", taken_valid, 1);
      chk("stall_flag_z", flag_z, 0);
    end
    idle(); stall = 1; flush = 1;
    tick();
    chk("flush_valid", taken_valid, 0);
    chk("flush_taken", taken, 0);
    idle(); flush = 1; br_valid = 1; br_cond = 3'd7;
    tick();
    chk("flush_nocount", br_total, m_total);
    // partial write
    set_flags(1, 0, 0);
    wr_z = 1; alu_zr = 0; alu_neg = 1;
    tick();
    chk("part_z", flag_z, 0);
    chk("part_n", flag_n, 0);
    idle();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cnt_clr = ($urandom_range(0, 99) == 0);
      {alu_zr, alu_neg, alu_ov} = 3'($urandom);
      {wr_z, wr_n, wr_v} = 3'($urandom);
      br_valid = $urandom_range(0, 2) != 0;
      br_cond = 3'($urandom);
      tick();
    end
    // saturation
    idle(); cnt_clr = 1;
    tick();
    cnt_clr = 0; br_valid = 1; br_cond = 3'd7;
    for (int i = 0; i < MAXC; i++) tick();
    chk("sat_total", br_total, 16'hFFFF);
    chk("sat_taken", br_taken, 16'hFFFF);
    tick();
    chk("sat_total_hold", br_total, 16'hFFFF);
    chk("sat_taken_hold", br_taken, 16'hFFFF);
    cnt_clr = 1;
    tick();
    chk("clr_total", br_total, 0);
    chk("clr_taken", br_taken, 0);
    // async reset mid-branch
    idle(); br_valid = 1; br_cond = 3'd7;
    set_flags(0, 1, 1);
    br_valid = 1; br_cond = 3'd7;
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #3 rst_n = 1'b1;
    idle();
    @(negedge clk);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
